// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_if
//  Brief    : Request/control bundle between the pipeline hazard sources and
//             the stall/flush sequencer (pipe_ctrl).
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
) ();
  // Requests toward the sequencer
  logic             hazard;
  logic             branch_taken;
  logic             jump;
  logic             dmem_req;
  logic             dmem_ready;
  logic             mdu_start;
  logic             mdu_done;
  logic             halt;
  logic             resume;
  // Per-stage controls and status from the sequencer
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_bubble;
  logic             ex_mem_stall;
  logic             mem_wb_bubble;
  logic             pc_redirect;
  logic             halted;
  logic             mdu_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: raises requests, consumes controls
  modport master (
    output hazard, branch_taken, jump, dmem_req, dmem_ready,
           mdu_start, mdu_done, halt, resume,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
           ex_mem_stall, mem_wb_bubble, pc_redirect, halted, mdu_timeout,
           stall_cnt, flush_cnt
  );

  // Sequencer side
  modport slave (
    input  hazard, branch_taken, jump, dmem_req, dmem_ready,
           mdu_start, mdu_done, halt, resume,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
           ex_mem_stall, mem_wb_bubble, pc_redirect, halted, mdu_timeout,
           stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Brief    : Stall/flush sequencer for the 5-stage RV32 pipeline. Merges
//             hazard, redirect, memory-wait, MDU and halt requests into
//             per-stage stall/flush/bubble controls (Mealy) and keeps
//             saturating stall/flush performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64,
  parameter int DRAIN_CYC   = 3
) (
  input  wire logic   clk_i,
  input  wire logic   rst_i,
  pipe_ctrl_if.slave  bus
);

  localparam int c_MDU_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam int c_DRN_W = $clog2(DRAIN_CYC + 1);

  localparam logic [c_MDU_W-1:0] c_MDU_LAST = c_MDU_W'(MDU_TIMEOUT - 1);
  localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'(DRAIN_CYC - 1);

  localparam logic [2:0] c_RUN      = 3'd0;
  localparam logic [2:0] c_MEM_WAIT = 3'd1;
  localparam logic [2:0] c_MDU_WAIT = 3'd2;
  localparam logic [2:0] c_DRAIN    = 3'd3;
  localparam logic [2:0] c_HALT     = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [c_MDU_W-1:0] r_mdu_cnt;
  logic [c_DRN_W-1:0] r_drain_cnt;
  logic               r_mdu_timeout;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic w_mem_wait;
  logic w_mdu_clr, w_mdu_inc, w_drn_clr, w_drn_inc, w_timeout_set;

  logic w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_stall;
  logic w_id_ex_bubble, w_ex_mem_stall, w_mem_wb_bubble, w_pc_redirect;
  logic w_halted;

  // A data access that is not finishing this cycle freezes the whole pipe
  assign w_mem_wait = bus.dmem_req & ~bus.dmem_ready;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= c_RUN;
    else       r_state <= w_next_state;
  end

  // Next-state selection plus MDU/drain counter commands
  always_comb begin
    w_next_state  = r_state;
    w_mdu_clr     = 1'b0;
    w_mdu_inc     = 1'b0;
    w_drn_clr     = 1'b0;
    w_drn_inc     = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      c_RUN: begin
        if (w_mem_wait) begin
          w_next_state = c_MEM_WAIT;
        end else if (bus.mdu_start) begin
          w_next_state = c_MDU_WAIT;
          w_mdu_clr    = 1'b1;
        end else if (bus.branch_taken) begin
          w_next_state = c_RUN;   // redirect wins over halt/jump/hazard
        end else if (bus.halt) begin
          w_next_state = c_DRAIN;
          w_drn_clr    = 1'b1;
        end
      end
      c_MEM_WAIT: begin
        if (bus.dmem_ready) w_next_state = c_RUN;
      end
      c_MDU_WAIT: begin
        // A memory freeze suspends MDU bookkeeping for that cycle
        if (!w_mem_wait) begin
          if (bus.mdu_done) begin
            w_next_state = c_RUN;
          end else if (r_mdu_cnt == c_MDU_LAST) begin
            w_next_state  = c_RUN;
            w_timeout_set = 1'b1;
          end else begin
            w_mdu_inc = 1'b1;
          end
        end
      end
      c_DRAIN: begin
        // Only cycles in which EX/MEM/WB actually advance are counted
        if (!w_mem_wait) begin
          if (r_drain_cnt == c_DRN_LAST) w_next_state = c_HALT;
          else                           w_drn_inc    = 1'b1;
        end
      end
      c_HALT: begin
        if (bus.resume) w_next_state = c_RUN;
      end
      default: w_next_state = c_RUN;
    endcase
  end

  // Mealy control outputs; forced low while reset is held
  always_comb begin
    logic v_freeze;
    logic v_hold;
    v_freeze        = 1'b0;
    v_hold          = 1'b0;
    w_if_id_flush   = 1'b0;
    w_pc_redirect   = 1'b0;
    w_halted        = 1'b0;
    w_id_ex_bubble  = 1'b0;
    if (!rst_i) begin
      case (r_state)
        c_RUN: begin
          if (w_mem_wait || bus.mdu_start) begin
            v_freeze = 1'b1;
          end else if (bus.branch_taken) begin
            w_pc_redirect  = 1'b1;
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
          end else if (bus.halt) begin
            v_hold = 1'b1;
          end else if (bus.jump) begin
            w_pc_redirect = 1'b1;
            w_if_id_flush = 1'b1;
          end else if (bus.hazard) begin
            v_hold = 1'b1;
          end
        end
        c_MEM_WAIT: v_freeze = ~bus.dmem_ready;
        c_MDU_WAIT: begin
          if (w_mem_wait)
            v_freeze = 1'b1;
          else if (!bus.mdu_done && (r_mdu_cnt != c_MDU_LAST))
            v_freeze = 1'b1;
        end
        c_DRAIN: begin
          if (w_mem_wait) v_freeze = 1'b1;
          else            v_hold   = 1'b1;
        end
        c_HALT: begin
          if (!bus.resume) begin
            w_halted = 1'b1;
            v_hold   = 1'b1;
          end
        end
        default: v_freeze = 1'b0;
      endcase
    end
    // v_hold: front end held, bubble into EX; v_freeze: every stage held
    w_pc_stall      = v_freeze | v_hold;
    w_if_id_stall   = v_freeze | v_hold;
    w_id_ex_stall   = v_freeze;
    w_ex_mem_stall  = v_freeze;
    w_mem_wb_bubble = v_freeze;
    w_id_ex_bubble  = w_id_ex_bubble | v_hold;
  end

  // MDU/drain counters, sticky timeout flag and saturating perf counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mdu_cnt     <= '0;
      r_drain_cnt   <= '0;
      r_mdu_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      if (w_mdu_clr)      r_mdu_cnt   <= '0;
      else if (w_mdu_inc) r_mdu_cnt   <= r_mdu_cnt + c_MDU_W'(1);
      if (w_drn_clr)      r_drain_cnt <= '0;
      else if (w_drn_inc) r_drain_cnt <= r_drain_cnt + c_DRN_W'(1);
      if (w_timeout_set)  r_mdu_timeout <= 1'b1;
      if (w_pc_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_if_id_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_stall      = w_pc_stall;
  assign bus.if_id_stall   = w_if_id_stall;
  assign bus.if_id_flush   = w_if_id_flush;
  assign bus.id_ex_stall   = w_id_ex_stall;
  assign bus.id_ex_bubble  = w_id_ex_bubble;
  assign bus.ex_mem_stall  = w_ex_mem_stall;
  assign bus.mem_wb_bubble = w_mem_wb_bubble;
  assign bus.pc_redirect   = w_pc_redirect;
  assign bus.halted        = w_halted;
  assign bus.mdu_timeout   = r_mdu_timeout;
  assign bus.stall_cnt     = r_stall_cnt;
  assign bus.flush_cnt     = r_flush_cnt;

endmodule
`default_nettype wire
